// File: rtl/seg7_capture.sv
// seg7_capture: recovers the byte shown on a 2-digit multiplexed 7-segment bus
// Ports:
//   clk_i    - single clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   seg_i    - segment lines a..g (bit 6 = a), active-high, asynchronous
//   sel_i    - digit select: 10 = low nibble, 01 = high nibble, 00/11 = blank
//   value_o  - last assembled byte {hi,lo}, held between updates
//   valid_o  - one-cycle pulse when value_o updates
//   err_o    - one-cycle pulse on an undecodable pattern under a valid select
module seg7_capture #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] seg_i,
    input  logic [1:0] sel_i,
    output logic [7:0] value_o,
    output logic       valid_o,
    output logic       err_o
);
    typedef enum logic [1:0] {EMPTY, HAVE_LO, HAVE_HI} state_t;

    // Returns {ok, nibble}; ok=0 for any pattern not in the hex glyph table.
    function automatic logic [4:0] dec(input logic [6:0] g);
        case (g)
            7'h7E: dec = 5'h10;
            7'h30: dec = 5'h11;
            7'h6D: dec = 5'h12;
            7'h79: dec = 5'h13;
            7'h33: dec = 5'h14;
            7'h5B: dec = 5'h15;
            7'h5F: dec = 5'h16;
            7'h70: dec = 5'h17;
            7'h7F: dec = 5'h18;
            7'h7B: dec = 5'h19;
            7'h77: dec = 5'h1A;
            7'h1F: dec = 5'h1B;
            7'h4E: dec = 5'h1C;
            7'h3D: dec = 5'h1D;
            7'h4F: dec = 5'h1E;
            7'h47: dec = 5'h1F;
            default: dec = 5'h00;
        endcase
    endfunction

    logic [8:0] sync_q, bus_q, prev_q;
    logic [7:0] stab_q, stab_d, value_q, value_d;
    logic [3:0] lo_q, lo_d, hi_q, hi_d;
    logic       valid_q, valid_d, err_q, err_d;
    state_t     state_q, state_d;
    logic       same, samp, lo_sel, hi_sel;
    logic [4:0] d;

    assign same   = bus_q == prev_q;
    // Fires only on the SETTLE-1 -> SETTLE step, so a static bus samples once.
    assign samp   = same && stab_q == 8'(SETTLE - 1);
    assign lo_sel = bus_q[8:7] == 2'b10;
    assign hi_sel = bus_q[8:7] == 2'b01;
    assign d      = dec(bus_q[6:0]);
    assign stab_d = !same ? 8'd0 : (stab_q == 8'(SETTLE) ? stab_q : stab_q + 8'd1);

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        value_d = value_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (samp && (lo_sel || hi_sel)) begin
            if (!d[4]) begin
                err_d   = 1'b1;
                state_d = EMPTY;
                lo_d    = 4'h0;
                hi_d    = 4'h0;
            end else if (lo_sel) begin
                lo_d = d[3:0];
                if (state_q == HAVE_HI) begin
                    value_d = {hi_q, d[3:0]};
                    valid_d = 1'b1;
                    state_d = EMPTY;
                end else begin
                    state_d = HAVE_LO;
                end
            end else begin
                hi_d = d[3:0];
                if (state_q == HAVE_LO) begin
                    value_d = {d[3:0], lo_q};
                    valid_d = 1'b1;
                    state_d = EMPTY;
                end else begin
                    state_d = HAVE_HI;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            bus_q   <= '0;
            prev_q  <= '0;
            stab_q  <= '0;
            state_q <= EMPTY;
            lo_q    <= '0;
            hi_q    <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sel_i, seg_i};
            bus_q   <= sync_q;
            prev_q  <= bus_q;
            stab_q  <= stab_d;
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign value_o = value_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed checks of display-bus byte recovery
module tb_seg7_capture;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg = '0;
    logic [1:0] sel = '0;
    logic [7:0] value;
    logic       valid, err;
    int         nvec = 0, nerr = 0;
    int         cyc = 0, vcnt = 0, ecnt = 0, both = 0, vcyc = 0, t0 = 0;
    int         v0, e0, t1;
    logic [7:0] last_val = '0;

    seg7_capture #(.SETTLE(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .seg_i(seg), .sel_i(sel),
        .value_o(value), .valid_o(valid), .err_o(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valid) begin
            vcnt = vcnt + 1;
            vcyc = cyc;
            last_val = value;
        end
        if (err) ecnt = ecnt + 1;
        if (valid && err) both = both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic [6:0] g, input int n);
        @(negedge clk);
        #1;
        sel = s;
        seg = g;
        t0 = cyc;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_value", 32'(value), 32'h00);
        check("rst_valid", 32'(valid), 0);
        check("rst_err", 32'(err), 0);

        v0 = vcnt; e0 = ecnt;
        drive(2'b10, 7'h7E, 8);
        drive(2'b01, 7'h30, 10);
        t1 = t0;
        check("t1_count", 32'(vcnt - v0), 1);
        check("t1_latency", 32'(vcyc - t1), 7);
        check("t1_value", 32'(last_val), 32'h10);
        check("t1_err", 32'(ecnt - e0), 0);

        for (int i = 0; i < 3; i++) begin
            v0 = vcnt;
            drive(2'b10, 7'h47, 12);
            drive(2'b01, 7'h77, 12);
            check("t2_count", 32'(vcnt - v0), 1);
            check("t2_value", 32'(value), 32'hAF);
        end

        v0 = vcnt; e0 = ecnt;
        drive(2'b10, 7'h6D, 10);
        drive(2'b10, 7'h00, 2);
        drive(2'b01, 7'h4F, 12);
        check("t3_count", 32'(vcnt - v0), 1);
        check("t3_value", 32'(value), 32'hE2);
        check("t3_err", 32'(ecnt - e0), 0);

        v0 = vcnt; e0 = ecnt;
        drive(2'b10, 7'h5B, 10);
        drive(2'b01, 7'h7C, 12);
        check("t4_err", 32'(ecnt - e0), 1);
        check("t4_novalid", 32'(vcnt - v0), 0);
        check("t4_hold", 32'(value), 32'hE2);
        drive(2'b10, 7'h33, 10);
        drive(2'b01, 7'h7B, 12);
        check("t4_count", 32'(vcnt - v0), 1);
        check("t4_value", 32'(value), 32'h94);

        v0 = vcnt; e0 = ecnt;
        drive(2'b10, 7'h79, 10);
        drive(2'b00, 7'h79, 20);
        drive(2'b10, 7'h70, 10);
        drive(2'b01, 7'h3D, 12);
        check("t5_count", 32'(vcnt - v0), 1);
        check("t5_value", 32'(value), 32'hD7);
        check("t5_err", 32'(ecnt - e0), 0);

        drive(2'b10, 7'h4F, 10);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        sel = 2'b00;
        seg = 7'h00;
        #1 check("t6_async_rst", 32'(value), 32'h00);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        v0 = vcnt; e0 = ecnt;
        drive(2'b01, 7'h1F, 12);
        check("t6_value0", 32'(value), 32'h00);
        check("t6_novalid", 32'(vcnt - v0), 0);
        check("t6_noerr", 32'(ecnt - e0), 0);
        drive(2'b10, 7'h7E, 12);
        check("t6_count", 32'(vcnt - v0), 1);
        check("t6_value", 32'(value), 32'hB0);

        check("valid_err_excl", 32'(both), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
